// File: rtl/sdram_model.sv
// rtl/sdram_model.sv - cycle-accurate SDRAM device responder
// Decodes controller command pins, models banks, one shared burst engine and a CAS-latency output pipeline.
module sdram_model #(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 9,
   parameter int DW       = 16,
   parameter int TRCD     = 3,
   parameter int TRFC     = 7
) (
   input  logic          clk_100m,
   input  logic          rst_n,
   input  logic          sdram_cke,
   input  logic          sdram_cs_n,
   input  logic          sdram_ras_n,
   input  logic          sdram_cas_n,
   input  logic          sdram_we_n,
   input  logic [1:0]    sdram_ba,
   input  logic [12:0]   sdram_addr,
   input  logic [DW-1:0] sdram_dq_in,
   output logic [DW-1:0] sdram_dq_out,
   output logic          sdram_dq_oe,
   output logic          init_done,
   output logic          err,
   output logic [15:0]   ref_cnt
);
   localparam int AW = 2 + ROW_BITS + COL_BITS;
   localparam int TW = $clog2(TRCD + 1);
   localparam int RW = $clog2(TRFC + 1);
   localparam logic [COL_BITS:0] ONE  = {{COL_BITS{1'b0}}, 1'b1};
   localparam logic [COL_BITS:0] PAGE = {1'b1, {COL_BITS{1'b0}}};

   typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_MRS, C_BST} cmd_e;
   typedef enum logic [2:0] {I_WAIT_PRE, I_WAIT_AR1, I_WAIT_AR2, I_WAIT_MRS, I_READY} init_e;

   init_e                    init_q, init_d;
   logic [1:0]               cl_q, cl_d;
   logic [2:0]               bl_q, bl_d;
   logic                     single_q, single_d;
   logic [3:0]               open_q, open_d;
   logic [3:0][ROW_BITS-1:0] row_q, row_d;
   logic [3:0][TW-1:0]       trcd_q, trcd_d;
   logic [RW-1:0]            rfc_q, rfc_d;
   logic [15:0]              ref_q, ref_d;
   logic                     err_q, err_d;
   logic                     bact_q, bact_d, bwr_q, bwr_d;
   logic [1:0]               bba_q, bba_d;
   logic [ROW_BITS-1:0]      brow_q, brow_d;
   logic [COL_BITS-1:0]      bcol_q, bcol_d;
   logic [COL_BITS:0]        bleft_q, bleft_d;
   logic [2:0]               poe_q, poe_d;
   logic [2:0][DW-1:0]       pdat_q, pdat_d;

   logic [12:0]         a;
   cmd_e                cmd;
   logic                cmd_acc;
   logic [COL_BITS:0]   blen, blen_m1, blen_eff;
   logic [COL_BITS-1:0] mask, col;
   logic                beat_v, beat_wr;
   logic [AW-1:0]       beat_idx;
   logic [DW-1:0]       mem [1<<AW];
   logic                unused_ok;

   function automatic logic [COL_BITS-1:0] nxt(input logic [COL_BITS-1:0] c,
                                                input logic [COL_BITS-1:0] m);
      return (c & ~m) | ((c + 1'b1) & m);
   endfunction

   // Pin vector index 0 carries A12; a[n] is An.
   always_comb begin
      for (int i = 0; i < 13; i++) a[i] = sdram_addr[12 - i];
   end

   always_comb begin
      cmd = C_NOP;
      if (sdram_cke && !sdram_cs_n) begin
         case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
            3'b011:  cmd = C_ACT;
            3'b101:  cmd = C_RD;
            3'b100:  cmd = C_WR;
            3'b010:  cmd = C_PRE;
            3'b001:  cmd = C_REF;
            3'b000:  cmd = C_MRS;
            3'b110:  cmd = C_BST;
            default: cmd = C_NOP;
         endcase
      end
   end

   assign cmd_acc = (cmd != C_NOP) && (rfc_q == '0);
   assign col     = a[COL_BITS-1:0];

   always_comb begin
      case (bl_q)
         3'd0:    blen = ONE;
         3'd1:    blen = ONE << 1;
         3'd2:    blen = ONE << 2;
         3'd3:    blen = ONE << 3;
         default: blen = PAGE;
      endcase
      blen_m1 = blen - ONE;
      mask    = blen_m1[COL_BITS-1:0];
   end

   always_comb begin
      cl_d = cl_q;  bl_d = bl_q;  single_d = single_q;
      open_d = open_q;  row_d = row_q;  ref_d = ref_q;  err_d = 1'b0;
      bact_d = bact_q;  bwr_d = bwr_q;  bba_d = bba_q;  brow_d = brow_q;
      bcol_d = bcol_q;  bleft_d = bleft_q;  blen_eff = blen;
      rfc_d = (rfc_q != '0) ? rfc_q - 1'b1 : rfc_q;
      for (int b = 0; b < 4; b++) trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - 1'b1 : trcd_q[b];
      beat_v   = bact_q;
      beat_wr  = bwr_q;
      beat_idx = {bba_q, brow_q, bcol_q};
      if (bact_q) begin
         bcol_d  = nxt(bcol_q, mask);
         bleft_d = bleft_q - ONE;
         bact_d  = (bleft_q != ONE);
      end
      if (cmd != C_NOP && !cmd_acc) begin
         err_d = 1'b1;
      end else if (cmd_acc) begin
         case (cmd)
            C_ACT: begin
               if (!init_done || open_q[sdram_ba]) err_d = 1'b1;
               else begin
                  open_d[sdram_ba] = 1'b1;
                  row_d[sdram_ba]  = a[ROW_BITS-1:0];
                  trcd_d[sdram_ba] = TW'(TRCD - 1);
               end
            end
            C_RD, C_WR: begin
               if (!init_done || !open_q[sdram_ba] || trcd_q[sdram_ba] != '0) err_d = 1'b1;
               else begin
                  // A new access replaces any burst in progress on the same edge.
                  if (cmd == C_WR && single_q) blen_eff = ONE;
                  beat_v   = 1'b1;
                  beat_wr  = (cmd == C_WR);
                  beat_idx = {sdram_ba, row_q[sdram_ba], col};
                  bact_d   = (blen_eff != ONE);
                  bwr_d    = (cmd == C_WR);
                  bba_d    = sdram_ba;
                  brow_d   = row_q[sdram_ba];
                  bcol_d   = nxt(col, mask);
                  bleft_d  = blen_eff - ONE;
               end
            end
            C_PRE: begin
               if (a[10]) open_d = '0;
               else open_d[sdram_ba] = 1'b0;
               if (a[10] || sdram_ba == bba_q) begin
                  beat_v = 1'b0;
                  bact_d = 1'b0;
               end
            end
            C_REF: begin
               ref_d = ref_q + 1'b1;
               rfc_d = RW'(TRFC);
               if (|open_q) err_d = 1'b1;
            end
            C_MRS: begin
               if (a[6:4] == 3'd2 || a[6:4] == 3'd3) cl_d = a[5:4];
               else begin
                  cl_d  = 2'd3;
                  err_d = 1'b1;
               end
               if (a[2:0] <= 3'd3 || a[2:0] == 3'd7) bl_d = a[2:0];
               else err_d = 1'b1;
               single_d = a[9];
            end
            C_BST: begin
               beat_v = 1'b0;
               bact_d = 1'b0;
            end
            default: ;
         endcase
      end
      poe_d  = {poe_q[1:0], beat_v && !beat_wr};
      pdat_d = {pdat_q[1:0], (beat_v && !beat_wr) ? mem[beat_idx] : '0};
   end

   always_comb begin
      init_d = init_q;
      if (cmd_acc) begin
         case (init_q)
            I_WAIT_PRE: if (cmd == C_PRE) init_d = I_WAIT_AR1;
            I_WAIT_AR1: if (cmd == C_REF) init_d = I_WAIT_AR2;
            I_WAIT_AR2: if (cmd == C_REF) init_d = I_WAIT_MRS;
            I_WAIT_MRS: if (cmd == C_MRS) init_d = I_READY;
            default:    init_d = init_q;
         endcase
      end
   end

   always_comb begin
      init_done = (init_q == I_READY);
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         init_q <= I_WAIT_PRE;
         cl_q <= 2'd3;  bl_q <= 3'd7;  single_q <= 1'b0;
         open_q <= '0;  row_q <= '0;  trcd_q <= '0;  rfc_q <= '0;
         ref_q <= '0;  err_q <= 1'b0;
         bact_q <= 1'b0;  bwr_q <= 1'b0;  bba_q <= '0;  brow_q <= '0;
         bcol_q <= '0;  bleft_q <= '0;  poe_q <= '0;  pdat_q <= '0;
      end else begin
         init_q <= init_d;
         cl_q <= cl_d;  bl_q <= bl_d;  single_q <= single_d;
         open_q <= open_d;  row_q <= row_d;  trcd_q <= trcd_d;  rfc_q <= rfc_d;
         ref_q <= ref_d;  err_q <= err_d;
         bact_q <= bact_d;  bwr_q <= bwr_d;  bba_q <= bba_d;  brow_q <= brow_d;
         bcol_q <= bcol_d;  bleft_q <= bleft_d;  poe_q <= poe_d;  pdat_q <= pdat_d;
      end
   end

   // Array has no reset so contents survive a mid-burst reset.
   always_ff @(posedge clk_100m) begin
      if (beat_v && beat_wr) mem[beat_idx] <= sdram_dq_in;
   end

   assign sdram_dq_oe  = (cl_q == 2'd2) ? poe_q[1] : poe_q[2];
   assign sdram_dq_out = (cl_q == 2'd2) ? pdat_q[1] : pdat_q[2];
   assign err          = err_q;
   assign ref_cnt      = ref_q;
   assign unused_ok    = ^{a, blen_m1[COL_BITS]};
endmodule

// File: tb/tb_sdram_model.sv
// tb/tb_sdram_model.sv - directed self-checking bench for sdram_model
// Commands are driven 1 unit after a rising edge and outputs sampled there too.
module tb_sdram_model;
   localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD  = 4'b0101, WR  = 4'b0100;
   localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000, BST = 4'b0110;

   logic        clk_100m = 1'b0;
   logic        rst_n;
   logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;
   logic [15:0] sdram_dq_in;
   logic [15:0] sdram_dq_out;
   logic        sdram_dq_oe;
   logic        init_done;
   logic        err;
   logic [15:0] ref_cnt;
   int          total = 0;
   int          bad = 0;

   sdram_model dut (
      .clk_100m    (clk_100m),
      .rst_n       (rst_n),
      .sdram_cke   (sdram_cke),
      .sdram_cs_n  (sdram_cs_n),
      .sdram_ras_n (sdram_ras_n),
      .sdram_cas_n (sdram_cas_n),
      .sdram_we_n  (sdram_we_n),
      .sdram_ba    (sdram_ba),
      .sdram_addr  (sdram_addr),
      .sdram_dq_in (sdram_dq_in),
      .sdram_dq_out(sdram_dq_out),
      .sdram_dq_oe (sdram_dq_oe),
      .init_done   (init_done),
      .err         (err),
      .ref_cnt     (ref_cnt)
   );

   always #5 clk_100m = ~clk_100m;

   function automatic logic [12:0] pins(input logic [12:0] av);
      logic [12:0] r;
      for (int i = 0; i < 13; i++) r[12 - i] = av[i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nop(input int n);
      repeat (n) begin
         @(posedge clk_100m);
         #1;
      end
   endtask

   task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] av,
                        input logic [15:0] d);
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
      sdram_ba    = b;
      sdram_addr  = pins(av);
      sdram_dq_in = d;
      @(posedge clk_100m);
      #1;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = NOP;
   endtask

   task automatic init_seq(input logic [12:0] mode);
      issue(PRE, 2'd0, 13'h400, 16'h0);
      chk("init_pre_err", err, 0);
      issue(REF, 2'd0, 13'h0, 16'h0);
      chk("init_ar1_err", err, 0);
      nop(7);
      issue(REF, 2'd0, 13'h0, 16'h0);
      nop(7);
      chk("init_done_before_mrs", init_done, 0);
      issue(MRS, 2'd0, mode, 16'h0);
      chk("init_done_after_mrs", init_done, 1);
      chk("init_mrs_err", err, 0);
      chk("init_ref_cnt", ref_cnt, 2);
   endtask

   initial begin
      rst_n = 1'b0;
      sdram_cke = 1'b1;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = NOP;
      sdram_ba = 2'd0;
      sdram_addr = 13'h0;
      sdram_dq_in = 16'h0;
      nop(2);
      chk("rst_oe", sdram_dq_oe, 0);
      chk("rst_dq", sdram_dq_out, 0);
      chk("rst_init", init_done, 0);
      chk("rst_err", err, 0);
      chk("rst_ref", ref_cnt, 0);
      rst_n = 1'b1;
      nop(1);

      init_seq(13'h037);

      // full-page write from col 510, wraps to cols 0..3
      issue(ACT, 2'd1, 13'h002, 16'h0);
      nop(2);
      issue(WR, 2'd1, 13'd510, 16'hA000);
      chk("wr_err", err, 0);
      for (int k = 1; k < 6; k++) begin
         sdram_dq_in = 16'hA000 + 16'(k);
         nop(1);
      end
      issue(BST, 2'd0, 13'h0, 16'hDEAD);
      issue(RD, 2'd1, 13'd510, 16'h0);
      nop(1);
      chk("rd_oe_early", sdram_dq_oe, 0);
      nop(1);
      chk("rd_b0_oe", sdram_dq_oe, 1);
      chk("rd_b0", sdram_dq_out, 16'hA000);
      nop(1);
      chk("rd_b1", sdram_dq_out, 16'hA001);
      nop(1);
      chk("rd_b2", sdram_dq_out, 16'hA002);
      nop(1);
      chk("rd_b3", sdram_dq_out, 16'hA003);
      issue(BST, 2'd0, 13'h0, 16'h0);
      chk("rd_b4", sdram_dq_out, 16'hA004);
      nop(1);
      chk("rd_b5", sdram_dq_out, 16'hA005);
      chk("bst_oe_tail", sdram_dq_oe, 1);
      nop(1);
      chk("bst_oe_low", sdram_dq_oe, 0);
      issue(RD, 2'd1, 13'd0, 16'h0);
      nop(2);
      chk("rd_col0", sdram_dq_out, 16'hA002);
      issue(BST, 2'd0, 13'h0, 16'h0);
      nop(4);

      // BL=4, CL=2
      issue(MRS, 2'd0, 13'h022, 16'h0);
      chk("mrs_bl4_err", err, 0);
      issue(WR, 2'd1, 13'd4, 16'hB004);
      for (int k = 5; k < 8; k++) begin
         sdram_dq_in = 16'hB000 + 16'(k);
         nop(1);
      end
      issue(RD, 2'd1, 13'd6, 16'hFFFF);
      nop(1);
      chk("bl4_b0", sdram_dq_out, 16'hB006);
      nop(1);
      chk("bl4_b1", sdram_dq_out, 16'hB007);
      nop(1);
      chk("bl4_b2", sdram_dq_out, 16'hB004);
      nop(1);
      chk("bl4_b3", sdram_dq_out, 16'hB005);
      chk("bl4_oe_b3", sdram_dq_oe, 1);
      nop(1);
      chk("bl4_oe_end", sdram_dq_oe, 0);

      // protocol violations
      issue(RD, 2'd2, 13'd0, 16'h0);
      chk("v_closed_err", err, 1);
      nop(1);
      chk("v_closed_clr", err, 0);
      issue(ACT, 2'd2, 13'h005, 16'h0);
      chk("v_act2_ok", err, 0);
      issue(RD, 2'd2, 13'd0, 16'h0);
      chk("v_trcd_err", err, 1);
      nop(1);
      chk("v_trcd_clr", err, 0);
      issue(ACT, 2'd1, 13'h003, 16'h0);
      chk("v_actopen_err", err, 1);
      nop(1);
      issue(PRE, 2'd0, 13'h400, 16'h0);
      chk("v_preall_ok", err, 0);
      issue(REF, 2'd0, 13'h0, 16'h0);
      chk("v_ref_ok", err, 0);
      nop(2);
      issue(BST, 2'd0, 13'h0, 16'h0);
      chk("v_trfc_err", err, 1);
      nop(1);
      chk("v_trfc_clr", err, 0);
      chk("v_ref_cnt", ref_cnt, 3);
      nop(5);

      // PRECHARGE interrupts a full-page read at T+5
      issue(MRS, 2'd0, 13'h037, 16'h0);
      issue(ACT, 2'd1, 13'h002, 16'h0);
      nop(2);
      issue(RD, 2'd1, 13'd510, 16'h0);
      nop(4);
      issue(PRE, 2'd1, 13'h000, 16'h0);
      nop(1);
      chk("int_oe_last", sdram_dq_oe, 1);
      chk("int_b4", sdram_dq_out, 16'hA004);
      nop(1);
      chk("int_oe_low", sdram_dq_oe, 0);

      // async reset mid-read, then write before init, then re-init and read back
      issue(ACT, 2'd1, 13'h002, 16'h0);
      nop(2);
      issue(RD, 2'd1, 13'd510, 16'h0);
      nop(3);
      chk("ar_oe_pre", sdram_dq_oe, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_oe_async", sdram_dq_oe, 0);
      chk("ar_init_async", init_done, 0);
      chk("ar_dq_async", sdram_dq_out, 0);
      nop(1);
      rst_n = 1'b1;
      issue(WR, 2'd1, 13'd0, 16'h5555);
      chk("v_wr_preinit_err", err, 1);
      nop(1);
      chk("v_wr_preinit_clr", err, 0);
      init_seq(13'h037);
      issue(ACT, 2'd1, 13'h002, 16'h0);
      nop(2);
      issue(RD, 2'd1, 13'd0, 16'h0);
      nop(2);
      chk("ret_col0", sdram_dq_out, 16'hA002);
      nop(1);
      chk("ret_col1", sdram_dq_out, 16'hA003);
      issue(BST, 2'd0, 13'h0, 16'h0);
      nop(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
